idex_stage: RTL and testbench
=============================

// Module: idex_stage
// PURPOSE
//  Parametrised ID/EX pipeline stage: successor to the fixed-width ID/EX latch. Carries decode
//  control, NUM_OPS operand words, funct, dest reg and immediate from ID to EX, adding a
//  valid/ready handshake, stall hold, synchronous flush (bubble insertion), a saturating
//  back-pressure counter and an optional skid entry. Sits between decode/regfile read and the ALU/FPU.
// PARAMETERS
//  CTRL_W      8   control bits {RWrite,DW,Float,WBsrc[1:0],MWrite,ALUop[1:0]}
//  DATA_W      32  width of one operand word
//  NUM_OPS     5   operand words (RegOut1..3, Float1P1, Float2P1)
//  FUN_W       6   funct field width
//  DST_W       5   destination register index width
//  IMM_W       16  immediate width
//  STALL_CNT_W 16  back-pressure counter width
// PORTS
//  clk        in   1               clock, all state updates on rising edge
//  rst_n      in   1               asynchronous active-low reset
//  flush      in   1               synchronous kill of stage contents
//  in_valid   in   1               ID presents a valid instruction
//  in_ready   out  1               stage can accept this cycle
//  in_ctrl    in   CTRL_W          decode control
//  in_ops     in   NUM_OPS*DATA_W  operands, word k at [k*DATA_W +: DATA_W]
//  in_fun     in   FUN_W           funct
//  in_dst     in   DST_W           destination register
//  in_imm     in   IMM_W           immediate
//  out_valid  out  1               EX-side instruction valid
//  out_ready  in   1               EX accepts this cycle
//  out_ctrl/out_ops/out_fun/out_dst/out_imm  out  (as inputs)  registered payload to EX
//  stall_cnt  out  STALL_CNT_W     cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, all payload outputs 0, stall_cnt=0, skid empty; in_ready=1 once released.
//  - Transfer: input accepted on edge where in_valid & in_ready; output consumed where out_valid & out_ready.
//  - Latency: accepted item appears on outputs 1 cycle later (out_valid=1 after the edge).
//  - Hold: out_valid & ~out_ready -> all outputs held stable, no payload change.
//  - out_ctrl forced to 0 whenever out_valid=0 (bubble = no RWrite/MWrite); other payload
//    fields hold their last value and are don't-care when invalid.
//  - flush=1: on that edge out_valid<=0, skid cleared; flush beats any simultaneous accept
//    (input handshake completes but item is discarded). stall_cnt unaffected.
//  - stall_cnt: +1 per cycle with out_valid & ~out_ready & ~flush; saturates at all-ones;
//    cleared only by rst_n.
//  - Mid-operation reset: async clear regardless of clk; in-flight item lost.
// CONFIGURATION
//  IDEX_SKID_EN undefined: single entry; in_ready = out_ready | ~out_valid (combinational path
//    from out_ready). Full throughput.
//  IDEX_SKID_EN defined: 2-entry elastic stage (main + skid). in_ready = ~skid_valid,
//    registered (no out_ready->in_ready comb path). If main full and not consumed while
//    input accepted, item goes to skid; on consume skid moves to main next edge. Order kept,
//    no loss/duplication; full throughput at steady state; flush clears both entries.
// TESTING
//  1 reset: rst_n low mid-cycle with out_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0 immediately.
//  2 stream: in_valid=1, out_ready=1, ops word0=1..8 -> out word0=1..8 one cycle late, no gaps.
//  3 stall: item ctrl=8'hA5 held, out_ready=0 4 cycles -> outputs stable, stall_cnt=4, in_ready=0 (no skid).
//  4 flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, out_ctrl=0; input dropped.
//  5 saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=4'hF and stays.
//  6 IDEX_SKID_EN: send A,B with out_ready=0 -> in_ready=0 after B; release -> A then B, in order.

Source files
------------

// File: rtl/idex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, stall counter.
// Define IDEX_SKID_EN for a 2-entry elastic stage with registered in_ready.
module idex_stage #(
    parameter int CTRL_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_OPS     = 5,
    parameter int FUN_W       = 6,
    parameter int DST_W       = 5,
    parameter int IMM_W       = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [FUN_W-1:0]          in_fun,
    input  logic [DST_W-1:0]          in_dst,
    input  logic [IMM_W-1:0]          in_imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [FUN_W-1:0]          out_fun,
    output logic [DST_W-1:0]          out_dst,
    output logic [IMM_W-1:0]          out_imm,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    localparam int PAY_W = CTRL_W + NUM_OPS*DATA_W + FUN_W + DST_W + IMM_W;

    logic [PAY_W-1:0]       w_in_pay;
    logic [CTRL_W-1:0]      w_main_ctrl;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_consume;
    logic                   r_main_valid;
    logic [PAY_W-1:0]       r_main_pay;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_in_pay  = {in_ctrl, in_ops, in_fun, in_dst, in_imm};
    assign w_accept  = in_valid & w_in_ready;
    assign w_consume = r_main_valid & out_ready;

    assign {w_main_ctrl, out_ops, out_fun, out_dst, out_imm} = r_main_pay;
    // Bubbles must never carry a register or memory write enable.
    assign out_ctrl  = r_main_valid ? w_main_ctrl : '0;
    assign out_valid = r_main_valid;
    assign in_ready  = w_in_ready;
    assign stall_cnt = r_stall_cnt;

`ifdef IDEX_SKID_EN
    logic             r_skid_valid;
    logic [PAY_W-1:0] r_skid_pay;

    assign w_in_ready = ~r_skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_pay   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_consume) begin
            if (r_skid_valid) begin
                r_main_pay   <= r_skid_pay;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_pay   <= w_in_pay;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is only ever empty when skid is empty, so this keeps order.
            if (r_main_valid) begin
                r_skid_pay   <= w_in_pay;
                r_skid_valid <= 1'b1;
            end else begin
                r_main_pay   <= w_in_pay;
                r_main_valid <= 1'b1;
            end
        end
    end
`else
    assign w_in_ready = out_ready | ~r_main_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_pay   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_pay   <= w_in_pay;
        end else if (w_consume) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && !flush && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: vector table, scoreboard, corner sequences.
module tb_idex_stage;

    localparam int CTRL_W  = 8;
    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 5;
    localparam int FUN_W   = 6;
    localparam int DST_W   = 5;
    localparam int IMM_W   = 16;
    localparam int SCW     = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [NUM_OPS*DATA_W-1:0] in_ops;
    logic [FUN_W-1:0]          in_fun;
    logic [DST_W-1:0]          in_dst;
    logic [IMM_W-1:0]          in_imm;
    logic                      out_valid;
    logic                      out_ready;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [NUM_OPS*DATA_W-1:0] out_ops;
    logic [FUN_W-1:0]          out_fun;
    logic [DST_W-1:0]          out_dst;
    logic [IMM_W-1:0]          out_imm;
    logic [SCW-1:0]            stall_cnt;

    idex_stage #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .FUN_W(FUN_W),
        .DST_W(DST_W), .IMM_W(IMM_W), .STALL_CNT_W(SCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_ops(in_ops), .in_fun(in_fun), .in_dst(in_dst), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_ops(out_ops), .out_fun(out_fun), .out_dst(out_dst),
        .out_imm(out_imm), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0]         ctrl;
        logic [NUM_OPS*DATA_W-1:0] ops;
        logic [FUN_W-1:0]          fun;
        logic [DST_W-1:0]          dst;
        logic [IMM_W-1:0]          imm;
    } pay_t;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [7:0] d;
        logic [7:0] c;
        logic       ev;
        logic [7:0] ed;
        logic [7:0] ec;
        logic       er;
        logic [3:0] es;
    } vec_t;

    pay_t sb_q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_OPS*DATA_W-1:0] mk_ops(input logic [7:0] d);
        logic [NUM_OPS*DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_OPS; k++)
            r[k*DATA_W +: DATA_W] = {8'(k), 16'h0, d};
        return r;
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [7:0] d, input logic [7:0] c);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_ops    = mk_ops(d);
        in_fun    = d[5:0];
        in_dst    = d[4:0];
        in_imm    = {d, ~d};
    endtask

    task automatic add(input logic iv, input logic ordy, input logic fl,
                       input logic [7:0] d, input logic [7:0] c,
                       input logic ev, input logic [7:0] ed, input logic [7:0] ec,
                       input logic er, input logic [3:0] es);
        vecs.push_back('{iv, ordy, fl, d, c, ev, ed, ec, er, es});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that performs them.
    always @(negedge clk) begin
        pay_t p;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", {248'h0, out_ops[7:0]}, 256'h0);
                end else begin
                    p = sb_q.pop_front();
                    check("sb_payload", {out_ctrl, out_ops, out_fun, out_dst, out_imm},
                          {p.ctrl, p.ops, p.fun, p.dst, p.imm});
                end
            end
            if (flush)
                sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back('{in_ctrl, in_ops, in_fun, in_dst, in_imm});
        end
    end

    initial begin
        int base;
        int exp_sc;

        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {255'h0, out_valid}, 256'h0);
        check("rst_out_ctrl", {248'h0, out_ctrl}, 256'h0);
        check("rst_out_ops", {96'h0, out_ops}, 256'h0);
        check("rst_stall_cnt", {252'h0, stall_cnt}, 256'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_in_ready", {255'h0, in_ready}, 256'h1);
        step();

`ifndef IDEX_SKID_EN
        for (int i = 1; i <= 8; i++)
            add(1, 1, 0, 8'(i), 8'(8'h10 + i), 1, 8'(i), 8'(8'h10 + i), 1, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 0, 8'h55, 8'hA5, 1, 8'h55, 8'hA5, 0, 0);
        for (int k = 1; k <= 4; k++)
            add(1, 0, 0, 8'h66, 8'h77, 1, 8'h55, 8'hA5, 0, 4'(k));
        add(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 4);
        add(1, 0, 0, 8'h21, 8'h3C, 1, 8'h21, 8'h3C, 0, 4);
        add(1, 1, 1, 8'h22, 8'h3D, 0, 8'h00, 8'h00, 1, 4);
        add(1, 0, 0, 8'h23, 8'h3E, 1, 8'h23, 8'h3E, 0, 4);
        add(1, 0, 1, 8'h24, 8'h3F, 0, 8'h00, 8'h00, 1, 4);
        add(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 4);
        add(1, 1, 1, 8'h26, 8'h40, 0, 8'h00, 8'h00, 1, 4);
        add(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 4);
        add(1, 1, 0, 8'h27, 8'h41, 1, 8'h27, 8'h41, 1, 4);
        add(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d, vecs[i].c);
            step();
            check($sformatf("vec%0d_out_valid", i), {255'h0, out_valid}, {255'h0, vecs[i].ev});
            check($sformatf("vec%0d_out_ctrl", i), {248'h0, out_ctrl}, {248'h0, vecs[i].ec});
            if (vecs[i].ev)
                check($sformatf("vec%0d_out_word0", i), {224'h0, out_ops[DATA_W-1:0]},
                      {248'h0, vecs[i].ed});
            check($sformatf("vec%0d_in_ready", i), {255'h0, in_ready}, {255'h0, vecs[i].er});
            check($sformatf("vec%0d_stall_cnt", i), {252'h0, stall_cnt}, {252'h0, vecs[i].es});
        end
        check("sb_drained", 256'(sb_q.size()), 256'h0);
        base = 4;
`else
        base = 0;
`endif

        // Saturation of the back-pressure counter under a long stall.
        drive(1, 0, 0, 8'h31, 8'h5A);
        step();
        check("sat_load_valid", {255'h0, out_valid}, 256'h1);
        for (int n = 1; n <= 20; n++) begin
            drive(0, 0, 0, 8'h00, 8'h00);
            step();
            exp_sc = (base + n > 15) ? 15 : base + n;
            check($sformatf("sat_cnt_%0d", n), {252'h0, stall_cnt}, 256'(exp_sc));
        end
        check("sat_hold_word0", {224'h0, out_ops[DATA_W-1:0]}, 256'h31);
        check("sat_hold_ctrl", {248'h0, out_ctrl}, 256'h5A);
        drive(0, 1, 0, 8'h00, 8'h00);
        step();
        check("sat_release_valid", {255'h0, out_valid}, 256'h0);
        check("sat_release_cnt", {252'h0, stall_cnt}, 256'hF);

        // Asynchronous reset in the middle of a cycle with a valid item held.
        drive(1, 0, 0, 8'h44, 8'hC3);
        step();
        check("midrst_pre_valid", {255'h0, out_valid}, 256'h1);
        drive(0, 0, 0, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {255'h0, out_valid}, 256'h0);
        check("midrst_out_ctrl", {248'h0, out_ctrl}, 256'h0);
        check("midrst_stall_cnt", {252'h0, stall_cnt}, 256'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("midrst_in_ready", {255'h0, in_ready}, 256'h1);
        step();
        check("midrst_post_valid", {255'h0, out_valid}, 256'h0);

`ifdef IDEX_SKID_EN
        drive(1, 0, 0, 8'h41, 8'h81);
        step();
        check("skid_a_valid", {255'h0, out_valid}, 256'h1);
        check("skid_a_in_ready", {255'h0, in_ready}, 256'h1);
        drive(1, 0, 0, 8'h42, 8'h82);
        step();
        check("skid_b_in_ready", {255'h0, in_ready}, 256'h0);
        check("skid_b_word0", {224'h0, out_ops[DATA_W-1:0]}, 256'h41);
        drive(1, 0, 0, 8'h43, 8'h83);
        step();
        check("skid_full_in_ready", {255'h0, in_ready}, 256'h0);
        check("skid_full_word0", {224'h0, out_ops[DATA_W-1:0]}, 256'h41);
        drive(0, 1, 0, 8'h00, 8'h00);
        step();
        check("skid_rel_valid", {255'h0, out_valid}, 256'h1);
        check("skid_rel_word0", {224'h0, out_ops[DATA_W-1:0]}, 256'h42);
        check("skid_rel_in_ready", {255'h0, in_ready}, 256'h1);
        step();
        check("skid_empty_valid", {255'h0, out_valid}, 256'h0);
`else
        drive(1, 0, 0, 8'h41, 8'h81);
        step();
        check("single_full_in_ready", {255'h0, in_ready}, 256'h0);
        drive(0, 1, 0, 8'h00, 8'h00);
        #1 check("single_comb_in_ready", {255'h0, in_ready}, 256'h1);
        step();
        check("single_empty_valid", {255'h0, out_valid}, 256'h0);
`endif
        step();
        check("sb_final_drained", 256'(sb_q.size()), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
